// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller and its queue.
package fetch_pkg;

    localparam int INST_BYTES  = 4;
    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Decode may request 3 pops; it can never take more than one fetch pair.
    function automatic logic [1:0] sat_pop(input logic [1:0] req);
        return (req == 2'd3) ? 2'd2 : req;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Dual-push / dual-pop circular buffer of fetch entries with synchronous flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4,
    localparam int PW = $clog2(QDEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [1:0]    pop_i,
    input  fetch_entry_t  push0_i,
    input  fetch_entry_t  push1_i,
    output fetch_entry_t  head0_o,
    output fetch_entry_t  head1_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [QDEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = {PW{1'b0}};
            wr_d  = {PW{1'b0}};
            cnt_d = {CW{1'b0}};
        end else begin
            rd_d  = rd_q + PW'(pop_i);
            wr_d  = push_i ? (wr_q + PW'(FETCH_WIDTH)) : wr_q;
            cnt_d = cnt_q - CW'(pop_i) + (push_i ? CW'(FETCH_WIDTH) : {CW{1'b0}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= {PW{1'b0}};
            wr_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q]          <= push0_i;
            mem_q[wr_q + PW'(1)] <= push1_i;
        end
    end

    assign head0_o = mem_q[rd_q];
    assign head1_o = mem_q[rd_q + PW'(1)];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches word pairs into a queue,
// presents two head instructions to decode and handles redirects/halt.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          MEM_LENGTH = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          QDEPTH     = 4,
    localparam int AW = $clog2(MEM_LENGTH),
    localparam int CW = $clog2(QDEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_word0,
    input  logic [31:0]   mem_word1,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          stall,
    input  logic [1:0]    pop_n,
    output logic [31:0]   inst0,
    output logic [31:0]   inst1,
    output logic [31:0]   pc0,
    output logic [31:0]   pc1,
    output logic          valid0,
    output logic          valid1,
    output logic          halted
);

    localparam logic [CW-1:0] PUSH_LIMIT = CW'(QDEPTH - FETCH_WIDTH);
    localparam logic [31:0]   PAIR_BYTES = 32'(INST_BYTES * FETCH_WIDTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [1:0]    pop_req;
    logic [1:0]    pop_eff;
    logic          push_en;
    logic          misaligned;
    logic [CW-1:0] count;
    fetch_entry_t  head0, head1;
    fetch_entry_t  push0, push1;

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    // Pops are clamped to occupancy; space freed by a pop is reusable the same cycle.
    always_comb begin
        pop_req = sat_pop(pop_n);
        pop_eff = pop_req;
        push_en = 1'b0;
        if (redirect) begin
            pop_eff = 2'd0;
            push_en = 1'b0;
        end else begin
            if (CW'(pop_req) > count) begin
                pop_eff = count[1:0];
            end else begin
                pop_eff = pop_req;
            end
            push_en = (state_q == FETCH) && !stall && ((count - CW'(pop_eff)) <= PUSH_LIMIT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect) begin
            state_d = misaligned ? HALTED : FETCH;
            pc_d    = misaligned ? pc_q : redirect_pc;
        end else if (push_en) begin
            state_d = state_q;
            pc_d    = pc_q + PAIR_BYTES;
        end else begin
            state_d = state_q;
            pc_d    = pc_q;
        end
    end

    always_comb begin
        halted = (state_q == HALTED);
        valid0 = (count != {CW{1'b0}});
        valid1 = (count >= CW'(2));
        inst0  = head0.inst;
        pc0    = head0.pc;
        inst1  = head1.inst;
        pc1    = head1.pc;
    end

    assign mem_addr = pc_q[AW-1:0];
    assign push0    = '{pc: pc_q, inst: mem_word0};
    assign push1    = '{pc: pc_q + 32'(INST_BYTES), inst: mem_word1};

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst     (reset),
        .flush_i (redirect),
        .push_i  (push_en),
        .pop_i   (pop_eff),
        .push0_i (push0),
        .push1_i (push1),
        .head0_o (head0),
        .head1_o (head1),
        .count_o (count)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl against a queue-level reference model.
module tb_fetch_ctrl;

    localparam int ML = 1024;
    localparam int QD = 4;
    localparam int AW = $clog2(ML);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_word0, mem_word1;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          stall = 1'b0;
    logic [1:0]    pop_n = 2'd0;
    logic [31:0]   inst0, inst1, pc0, pc1;
    logic          valid0, valid1, halted;

    logic [31:0]   mem_words [ML/4];
    logic [AW-3:0] widx, widx1;

    ent_t          exp_q[$];
    logic [31:0]   pc_m = 32'h0;
    logic          halted_m = 1'b0;
    logic          mon_en = 1'b0;
    int            checks = 0;
    int            errors = 0;

    fetch_ctrl #(.MEM_LENGTH(ML), .RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr),
        .mem_word0(mem_word0), .mem_word1(mem_word1),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall), .pop_n(pop_n),
        .inst0(inst0), .inst1(inst1), .pc0(pc0), .pc1(pc1),
        .valid0(valid0), .valid1(valid1), .halted(halted)
    );

    always #5 clk = ~clk;

    assign widx      = mem_addr[AW-1:2];
    assign widx1     = widx + {{(AW-3){1'b0}}, 1'b1};
    assign mem_word0 = mem_words[widx];
    assign mem_word1 = mem_words[widx1];

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        logic [AW-3:0] i;
        i = a[AW-1:2];
        return mem_words[i];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered stream of fetched entries, updated once per clock edge.
    task automatic model_step(input logic rd, input logic [31:0] rpc, input logic st, input logic [1:0] pn);
        int p;
        if (rd) begin
            exp_q.delete();
            if (rpc[1:0] != 2'b00) begin
                halted_m = 1'b1;
            end else begin
                halted_m = 1'b0;
                pc_m     = rpc;
            end
        end else begin
            p = (pn == 2'd3) ? 2 : int'(pn);
            if (p > exp_q.size()) p = exp_q.size();
            repeat (p) void'(exp_q.pop_front());
            if (!halted_m && !st && exp_q.size() <= QD - 2) begin
                exp_q.push_back('{pc: pc_m, inst: mem_at(pc_m)});
                exp_q.push_back('{pc: pc_m + 32'd4, inst: mem_at(pc_m + 32'd4)});
                pc_m = pc_m + 32'd8;
            end
        end
    endtask

    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic st, input logic [1:0] pn);
        redirect    = rd;
        redirect_pc = rpc;
        stall       = st;
        pop_n       = pn;
        @(posedge clk);
        model_step(rd, rpc, st, pn);
        #1;
    endtask

    task automatic apply_reset();
        redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0; pop_n = 2'd0;
        #1 reset = 1'b1;
        #1;
        check("rst_valid0", {31'h0, valid0}, 32'h0);
        check("rst_valid1", {31'h0, valid1}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        exp_q.delete();
        pc_m     = 32'h0;
        halted_m = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: compare presented heads and status against the model between edges.
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid0", {31'h0, valid0}, {31'h0, (exp_q.size() >= 1)});
            check("valid1", {31'h0, valid1}, {31'h0, (exp_q.size() >= 2)});
            check("halted", {31'h0, halted}, {31'h0, halted_m});
            check("mem_addr", 32'(mem_addr), 32'(pc_m[AW-1:0]));
            if (exp_q.size() >= 1 && valid0) begin
                check("inst0", inst0, exp_q[0].inst);
                check("pc0", pc0, exp_q[0].pc);
            end
            if (exp_q.size() >= 2 && valid1) begin
                check("inst1", inst1, exp_q[1].inst);
                check("pc1", pc1, exp_q[1].pc);
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        for (int i = 0; i < ML / 4; i++) mem_words[i] = $urandom;

        #2;
        check("init_valid0", {31'h0, valid0}, 32'h0);
        check("init_halted", {31'h0, halted}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Fill from reset, no pops: valid after one edge, full after two.
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        check("t1_valid1", {31'h0, valid1}, 32'h1);
        check("t1_inst0", inst0, mem_words[0]);
        check("t1_pc1", pc1, 32'h4);
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        check("t1_pc_hold", 32'(mem_addr), 32'h10);

        // Steady drain at two per cycle.
        repeat (6) begin
            cycle(1'b0, 32'h0, 1'b0, 2'd2);
            check("t2_nobubble", {30'h0, valid1, valid0}, 32'h3);
        end

        // Redirect while full with pops requested.
        cycle(1'b1, 32'h40, 1'b0, 2'd2);
        check("t3_flush", {31'h0, valid0}, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        check("t3_inst0", inst0, mem_words[16]);
        check("t3_pc0", pc0, 32'h40);

        // Misaligned redirect halts; aligned redirect resumes.
        cycle(1'b1, 32'h42, 1'b0, 2'd0);
        check("t4_halted", {31'h0, halted}, 32'h1);
        repeat (5) begin
            cycle(1'b0, 32'h0, 1'b0, 2'd0);
            check("t4_nopush", {31'h0, valid0}, 32'h0);
        end
        cycle(1'b1, 32'h44, 1'b0, 2'd0);
        check("t4_resume", {31'h0, halted}, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        check("t4_inst0", inst0, mem_words[17]);
        check("t4_inst1", inst1, mem_words[18]);

        // Memory-address wrap and 32-bit PC wrap.
        cycle(1'b1, 32'h3F0, 1'b0, 2'd0);
        repeat (6) cycle(1'b0, 32'h0, 1'b0, 2'd2);
        cycle(1'b1, 32'hFFFF_FFF0, 1'b0, 2'd0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 2'd2);
        check("t5_pc0_wrap", pc0, 32'h0);
        check("t5_inst0_wrap", inst0, mem_words[0]);

        // Pop clamping with pushes stalled.
        cycle(1'b1, 32'h100, 1'b0, 2'd0);
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        cycle(1'b0, 32'h0, 1'b1, 2'd1);
        check("t6_count1", {30'h0, valid1, valid0}, 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 2'd2);
        check("t6_clamp", {30'h0, valid1, valid0}, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 2'd3);
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        check("t6_pc0", pc0, 32'h108);

        // Asynchronous reset mid-operation.
        cycle(1'b1, 32'h43, 1'b0, 2'd0);
        apply_reset();
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        check("t6_after_rst", inst0, mem_words[0]);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                rpc = $urandom;
                if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
                cycle(($urandom_range(0, 19) == 0), rpc, ($urandom_range(0, 3) == 0),
                      2'($urandom_range(0, 3)));
            end
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller for the superscalar core.
- Owns the PC and drives the byte address of the dual-word instruction memory. That memory reads combinationally and returns the words at addr and addr+4.
- Buffers fetched instructions in a small queue and presents up to two head instructions per cycle to decode.
- Handles redirects (taken branch/jump) by flushing and refetching, and halts on a misaligned redirect.

Parameters:
- MEM_LENGTH, 1024, instruction memory size in bytes; power of two, >= 8.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- QDEPTH, 4, instruction queue entries; power of two, >= 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr  out  $clog2(MEM_LENGTH)  byte address to instruction memory; equals pc[$clog2(MEM_LENGTH)-1:0].
- mem_word0  in  32  instruction at mem_addr.
- mem_word1  in  32  instruction at mem_addr+4.
- redirect  in  1  flush queue and load redirect_pc.
- redirect_pc  in  32  redirect target.
- stall  in  1  suppress fetch pushes; pops still honoured.
- pop_n  in  2  instructions decode consumes this cycle (0, 1 or 2).
- inst0, inst1  out  32  queue head and head+1 instructions.
- pc0, pc1  out  32  PCs of inst0 and inst1.
- valid0, valid1  out  1  head / head+1 occupied.
- halted  out  1  controller in HALTED state.

Behaviour:
- Reset (async):
  - pc=RESET_PC, queue empty (rd_ptr=wr_ptr=count=0), state=FETCH.
  - valid0=valid1=0, halted=0.
  - inst*/pc* are don't-care while their valid bit is 0; the bench must not check them.
- States:
  - FETCH: normal operation.
  - HALTED: no pushes; the queue still drains via pop_n.
  - FETCH->HALTED on redirect with redirect_pc[1:0]!=0. The queue is flushed and pc is unchanged.
  - HALTED->FETCH on redirect with aligned redirect_pc. pc=redirect_pc and the queue is flushed.
- Outputs are combinational from queue state:
  - valid0 = count>=1, valid1 = count>=2.
  - inst0/pc0 = entry[rd_ptr], inst1/pc1 = entry[rd_ptr+1].
- Pop:
  - effective pops = min(pop_n, count); pop_n=3 is treated as 2.
  - rd_ptr advances by effective pops, modulo QDEPTH.
- Push (FETCH state, no redirect, stall=0):
  - Push only if count - pops <= QDEPTH-2.
  - Writes {pc, mem_word0} then {pc+4, mem_word1} at wr_ptr and wr_ptr+1.
  - wr_ptr += 2, pc += 8.
  - Otherwise pc holds.
- Same-cycle push and pop:
  - count_next = count - pops + pushes.
  - Space freed by a pop is usable in the same cycle.
- Redirect has highest priority:
  - Pops and pushes in that cycle are ignored, and the queue is emptied.
  - Aligned target: pc=redirect_pc. The first fetch from the new pc occurs the following cycle, so redirect-to-valid latency is 2 cycles.
- Latency:
  - First valid instruction appears 1 cycle after reset release.
  - Steady state delivers 2 instructions/cycle when pop_n=2 every cycle.
- Wrap-around:
  - pc is a 32-bit wrapping add; 32'hFFFF_FFF8+8 = 0.
  - mem_addr uses the low bits, so fetch wraps modulo MEM_LENGTH.
  - Queue pointers wrap modulo QDEPTH.
  - pc0/pc1 always carry the full 32-bit PC.
- Redirect target 4-aligned but not 8-aligned: legal; the pair is fetched from target and target+4.
- Reset asserted mid-operation: immediate return to reset values regardless of state or queue contents.
- No other flow control: decode must not pop beyond the valid bits. Excess pops are clamped, never underflow.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}.
  - enum fetch_state_t {FETCH, HALTED}.
  - localparam INST_BYTES=4, FETCH_WIDTH=2.
- One sub-module: fetch_queue, a dual-push/dual-pop circular buffer of fetch_entry_t with flush input and count output.
- fetch_ctrl keeps the PC register, state machine and push/pop arbitration.

Test Plan:
1. Reset release with RESET_PC=0, memory preloaded with words A,B,C,D at bytes 0,4,8,12, pop_n=0 -> after 1 cycle valid0=valid1=1, inst0=A, pc0=0, inst1=B, pc1=4. After 2 cycles the queue is full (count=4) and pc=16 holds.
2. Steady drain with pop_n=2 every cycle from the first valid -> consecutive pairs (A,B), (C,D), (E,F)... with pc0 advancing by 8 per cycle and no bubbles.
3. Redirect to 32'h40 while the queue is full and pop_n=2 in the same cycle -> next cycle valid0=0 with pops ignored. One cycle later inst0 = word@0x40 and pc0=32'h40.
4. Redirect to 32'h42 -> halted=1 and the queue is empty, with no pushes for 5 cycles. A subsequent redirect to 32'h44 -> halted=0, and inst0 = word@0x44, inst1 = word@0x48 two cycles later.
5. MEM_LENGTH=16, free-run pop_n=2 -> mem_addr sequence 0,8,0,8. pc0 reads 0,8,16,24 while instructions repeat with period 16 bytes.
6. Pop clamp and async reset: count=1 and pop_n=2 -> count becomes 0 (plus any push), no underflow. Asserting reset mid-clock -> valid0=0 and halted=0 immediately, before the next edge.
